// File: rtl/twowire_connect_pkg.sv
// Constants shared by the host connect generator and the DTM connect monitor.
// Both ends must agree on the LFSR polynomial, the seed, the field lengths and the FSM encodings.
package twowire_connect_pkg;

    localparam logic [5:0] LFSR_TAPS         = 6'h30;
    localparam logic [5:0] LFSR_INIT         = 6'h29;
    localparam int         CONNECT_LFSR_BITS = 64;
    localparam int         CONNECT_ADDR_BITS = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRE   = 3'd1;
    localparam logic [2:0] ST_SEQ   = 3'd2;
    localparam logic [2:0] ST_ADDR  = 3'd3;
    localparam logic [2:0] ST_ADDRN = 3'd4;

    // Shift left by one and feed the parity of the tapped bits back into bit 0.
    function automatic logic [5:0] lfsr_next(input logic [5:0] cur);
        return {cur[4:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/twowire_host_connect_gen_if.sv
// Link-controller side handshake and DIO pad signals of the connect generator.
// The master modport is the controller and pad; the slave modport is the generator.
interface twowire_host_connect_gen_if;
    logic       start;
    logic       abort;
    logic [3:0] addr;
    logic       adv;
    logic       dio_o;
    logic       dio_oe;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, addr, adv,
        input  dio_o, dio_oe, busy, done
    );

    modport slave (
        input  start, abort, addr, adv,
        output dio_o, dio_oe, busy, done
    );
endinterface

// File: rtl/twowire_connect_lfsr.sv
// 6-bit connect LFSR with synchronous seed load and step enable.
// The serial output is the MSB, so the seed's top bit is emitted first.
module twowire_connect_lfsr
    import twowire_connect_pkg::*;
(
    input  logic dck,
    input  logic drst,
    input  logic load,
    input  logic step,
    output logic out
);

    logic [5:0] lfsr;

    always_ff @(posedge dck or posedge drst) begin
        if (drst) begin
            lfsr <= LFSR_INIT;
        end else if (load) begin
            lfsr <= LFSR_INIT;
        end else if (step) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign out = lfsr[5];

endmodule

// File: rtl/twowire_host_connect_gen.sv
// Host-side Two-Wire connect sequence generator.
// It sends a zero preamble, 64 LFSR bits, the address nibble and then its complement.
module twowire_host_connect_gen
    import twowire_connect_pkg::*;
#(
    parameter int PREAMBLE_LEN = 8
) (
    input  logic                       dck,
    input  logic                       drst,
    twowire_host_connect_gen_if.slave  bus
);

    localparam int PCW = $clog2(PREAMBLE_LEN + 1);

    logic [2:0]     state;
    logic [3:0]     addr_q;
    logic [PCW-1:0] pre_cnt;
    logic [5:0]     bit_cnt;
    logic           done_q;
    logic           lfsr_out;
    logic           dio_bit;
    logic [1:0]     nib_idx;

    twowire_connect_lfsr u_lfsr (
        .dck  (dck),
        .drst (drst),
        .load (state == ST_IDLE && bus.start),
        .step (state == ST_SEQ && bus.adv && !bus.abort),
        .out  (lfsr_out)
    );

    always_ff @(posedge dck or posedge drst) begin
        if (drst) begin
            state   <= ST_IDLE;
            addr_q  <= 4'h0;
            pre_cnt <= '0;
            bit_cnt <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != ST_IDLE && bus.abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            addr_q  <= bus.addr;
                            pre_cnt <= '0;
                            bit_cnt <= 6'd0;
                            state   <= ST_PRE;
                        end
                    end
                    ST_PRE: begin
                        if (bus.adv) begin
                            if (pre_cnt == PCW'(PREAMBLE_LEN - 1)) begin
                                pre_cnt <= '0;
                                state   <= ST_SEQ;
                            end else begin
                                pre_cnt <= pre_cnt + 1'b1;
                            end
                        end
                    end
                    ST_SEQ: begin
                        if (bus.adv) begin
                            if (bit_cnt == 6'(CONNECT_LFSR_BITS - 1)) begin
                                bit_cnt <= 6'd0;
                                state   <= ST_ADDR;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (bus.adv) begin
                            if (bit_cnt[1:0] == 2'(CONNECT_ADDR_BITS - 1)) begin
                                bit_cnt <= 6'd0;
                                state   <= ST_ADDRN;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    ST_ADDRN: begin
                        if (bus.adv) begin
                            if (bit_cnt[1:0] == 2'(CONNECT_ADDR_BITS - 1)) begin
                                bit_cnt <= 6'd0;
                                done_q  <= 1'b1;
                                state   <= ST_IDLE;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Address nibble goes out MSB first: bit i of the field is addr_q[3-i].
    assign nib_idx = ~bit_cnt[1:0];

    always_comb begin
        dio_bit = 1'b0;
        case (state)
            ST_SEQ:   dio_bit = lfsr_out;
            ST_ADDR:  dio_bit = addr_q[nib_idx];
            ST_ADDRN: dio_bit = ~addr_q[nib_idx];
            default:  dio_bit = 1'b0;
        endcase
    end

    assign bus.dio_o  = dio_bit;
    assign bus.busy   = (state != ST_IDLE);
    assign bus.dio_oe = (state != ST_IDLE);
    assign bus.done   = done_q;

endmodule

// File: tb/tb_twowire_host_connect_gen.sv
// Directed bench for the host connect generator, including a loopback connect monitor.
module tb_twowire_host_connect_gen;

    logic dck = 1'b0;
    logic drst;
    int   n_vec = 0;
    int   n_err = 0;
    int   rel = 0;
    int   cn_cnt = 0;
    int   cn_rel = -1;

    bit       exp_bits [0:79];
    bit       got_bits [0:79];
    logic [79:0] mon_pat;
    logic [79:0] hist = '0;
    logic        dio_q = 1'b0;
    logic        adv_q = 1'b0;
    logic        connect_now;

    twowire_host_connect_gen_if bus();

    twowire_host_connect_gen #(.PREAMBLE_LEN(8)) dut (
        .dck  (dck),
        .drst (drst),
        .bus  (bus)
    );

    always #5 dck = ~dck;

    // Loopback: DIO passes through one register into a monitor for mdropaddr=5, connected=0.
    always @(posedge dck) begin
        dio_q <= bus.dio_o;
        adv_q <= bus.adv;
        if (adv_q) hist <= {hist[78:0], dio_q};
    end
    assign connect_now = adv_q && ({hist[78:0], dio_q} == mon_pat);
    always @(negedge dck) begin
        if (connect_now) begin
            cn_cnt = cn_cnt + 1;
            cn_rel = rel;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dck);
        #1;
    endtask

    task automatic build_exp(input logic [3:0] a);
        logic [5:0] s;
        s = 6'h29;
        for (int i = 0; i < 8; i++) exp_bits[i] = 1'b0;
        for (int i = 0; i < 64; i++) begin
            exp_bits[8+i] = s[5];
            s = {s[4:0], s[5] ^ s[4]};
        end
        for (int i = 0; i < 4; i++) begin
            exp_bits[72+i] = a[3-i];
            exp_bits[76+i] = ~a[3-i];
        end
    endtask

    // mode: 0 nominal, 1 adv one cycle in three, 2 start re-pulsed while busy, 3 abort, 4 reset
    task automatic run_seq(input logic [3:0] a, input int mode);
        int p;
        int last;
        int k;
        logic [6:0] v7;
        logic [7:0] v8;
        p    = (mode == 1) ? 3 : 1;
        last = 80 * p;
        build_exp(a);
        bus.addr  = a;
        bus.start = 1'b1;
        bus.adv   = (mode != 1);
        tick();
        bus.start = 1'b0;
        for (int r = 1; r <= last + 2; r++) begin
            rel = r;
            bus.adv = (r % p == 0);
            if (mode == 2 && (r == 3 || r == 77)) begin
                bus.start = 1'b1;
                bus.addr  = a ^ 4'hF;
            end else begin
                bus.start = 1'b0;
            end
            if (r <= last) begin
                k = (r - 1) / p;
                got_bits[k] = bus.dio_o;
                check("bit", {k[15:0], 15'd0, bus.dio_o}, {k[15:0], 15'd0, exp_bits[k]});
                check("oe_busy", {bus.dio_oe, bus.busy}, 2'b11);
            end
            check("done", bus.done, (r == last + 1));
            if (r == last + 1) check("idle_outs", {bus.dio_oe, bus.busy, bus.dio_o}, 3'b000);
            if (mode == 3 && r == 29) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                check("abort_outs", {bus.dio_oe, bus.busy, bus.done, bus.dio_o}, 4'b0000);
                for (int j = 0; j < 4; j++) begin
                    tick();
                    check("abort_nodone", {bus.busy, bus.done}, 2'b00);
                end
                return;
            end
            if (mode == 4 && r == 73) begin
                check("pre_rst_bit", bus.dio_o, 1'b1);
                #3 drst = 1'b1;
                #1 check("async_rst", {bus.dio_oe, bus.busy, bus.done, bus.dio_o}, 4'b0000);
                tick();
                drst = 1'b0;
                tick();
                check("rst_idle", {bus.dio_oe, bus.busy, bus.done}, 3'b000);
                return;
            end
            tick();
        end
        if (a == 4'hA) begin
            v7 = '0;
            v8 = '0;
            for (int i = 8; i <= 14; i++) v7 = {v7[5:0], got_bits[i]};
            for (int i = 72; i <= 79; i++) v8 = {v8[6:0], got_bits[i]};
            check("lfsr_head", v7, 7'b1010011);
            check("lfsr_first", got_bits[8], 1'b1);
            check("lfsr_last", got_bits[71], 1'b1);
            check("addr_field", v8, 8'b10100101);
        end
    endtask

    initial begin
        int base;
        build_exp(4'h5);
        for (int i = 0; i < 80; i++) mon_pat[79-i] = exp_bits[i];
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.addr  = 4'h0;
        bus.adv   = 1'b0;
        drst = 1'b1;
        tick();
        tick();
        check("reset_outs", {bus.dio_oe, bus.busy, bus.done, bus.dio_o}, 4'b0000);
        drst = 1'b0;
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("idle_abort", bus.busy, 1'b0);

        run_seq(4'hA, 0);
        tick();
        run_seq(4'hA, 1);
        tick();

        base = cn_cnt;
        run_seq(4'h5, 0);
        tick();
        check("loop_hit_cnt", cn_cnt - base, 1);
        check("loop_hit_cyc", cn_rel, 81);
        base = cn_cnt;
        run_seq(4'h4, 0);
        tick();
        check("loop_miss_cnt", cn_cnt - base, 0);

        run_seq(4'hA, 3);
        run_seq(4'hA, 0);
        tick();
        run_seq(4'hA, 4);
        run_seq(4'hA, 0);
        tick();
        run_seq(4'hA, 2);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
